// File: rtl/tlp_xcvr_pkg.sv
// Register channel map shared by the PCIe DMA application blocks.
// Host register writes arrive as {channel, 32-bit data} strobes.
package tlp_xcvr_pkg;

    typedef logic [3:0] ExtChan;

    localparam ExtChan F2C_BASE   = 4'd2;
    localparam ExtChan MTR_BASE   = 4'd3;
    localparam ExtChan DMA_ENABLE = 4'd4;
    localparam ExtChan F2C_RDPTR  = 4'd5;

endpackage

// File: rtl/f2c_dma_writer_if.sv
// Bundles the register channel, source stream, TLP beat stream and pointer
// outputs of the FPGA-to-CPU DMA writer; master is the writer side.
interface f2c_dma_writer_if;

    logic                 regWrValid_in;
    tlp_xcvr_pkg::ExtChan regWrChan_in;
    logic [31:0]          regWrData_in;
    logic [63:0]          f2cData_in;
    logic                 f2cValid_in;
    logic                 f2cReady_out;
    logic [63:0]          txData_out;
    logic                 txValid_out;
    logic                 txSop_out;
    logic                 txEop_out;
    logic                 txReady_in;
    logic [3:0]           wrPtr_out;
    logic [3:0]           rdPtr_out;

    modport master (
        input  regWrValid_in, regWrChan_in, regWrData_in,
        input  f2cData_in, f2cValid_in, txReady_in,
        output f2cReady_out, txData_out, txValid_out, txSop_out, txEop_out,
        output wrPtr_out, rdPtr_out
    );

    modport slave (
        output regWrValid_in, regWrChan_in, regWrData_in,
        output f2cData_in, f2cValid_in, txReady_in,
        input  f2cReady_out, txData_out, txValid_out, txSop_out, txEop_out,
        input  wrPtr_out, rdPtr_out
    );

endinterface

// File: rtl/f2c_dma_writer.sv
// Packs 16 source QWs into 128-byte writes to a 16-slot host ring, then posts wrPtr to the metrics QW.
// Request starts 2 cycles after enable; header/metrics beats held under txReady_in stall, data beats pass straight through.
module f2c_dma_writer
    import tlp_xcvr_pkg::*;
(
    input  logic             clk_in,
    input  logic             rstn,
    f2c_dma_writer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_HDR,
        ST_D_DATA,
        ST_M_HDR,
        ST_M_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_f2cBase;
    logic [31:0] r_mtrBase;
    logic        r_enable;
    logic        r_clrPending;
    logic [3:0]  r_wrPtr;
    logic [3:0]  r_rdPtr;
    logic [3:0]  r_beatCnt;
    logic [63:0] r_hdr;

    logic        w_txValid;
    logic        w_txSop;
    logic        w_txEop;
    logic [63:0] w_txData;
    logic        w_f2cReady;

    logic        w_wrF2cBase;
    logic        w_wrMtrBase;
    logic        w_wrEnable;
    logic        w_wrRdPtr;
    logic        w_full;
    logic        w_idleClr;
    logic        w_accept;
    logic        w_lastBeat;
    logic        w_startReq;
    logic [31:0] w_dataAddr;
    logic [31:0] w_mtrAddr;

    assign w_wrF2cBase = bus.regWrValid_in && (bus.regWrChan_in == F2C_BASE);
    assign w_wrMtrBase = bus.regWrValid_in && (bus.regWrChan_in == MTR_BASE);
    assign w_wrEnable  = bus.regWrValid_in && (bus.regWrChan_in == DMA_ENABLE);
    assign w_wrRdPtr   = bus.regWrValid_in && (bus.regWrChan_in == F2C_RDPTR);

    // One slot is sacrificed so that wrPtr == rdPtr unambiguously means empty.
    assign w_full      = (r_wrPtr + 4'd1) == r_rdPtr;
    assign w_idleClr   = (r_state == ST_IDLE) && r_clrPending;
    assign w_accept    = w_txValid && bus.txReady_in;
    assign w_lastBeat  = (r_state == ST_D_DATA) && w_accept && (r_beatCnt == 4'd15);
    assign w_startReq  = (r_state == ST_IDLE) && (w_next == ST_D_HDR);

    // Base registers hold QW addresses; the shift drops the top 3 bits.
    assign w_dataAddr  = (r_f2cBase << 3) + {21'd0, r_wrPtr, 7'd0};
    assign w_mtrAddr   = r_mtrBase << 3;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_clrPending && r_enable && !w_full) begin
                    w_next = ST_D_HDR;
                end
            end
            ST_D_HDR:  if (w_accept)   w_next = ST_D_DATA;
            ST_D_DATA: if (w_lastBeat) w_next = ST_M_HDR;
            ST_M_HDR:  if (w_accept)   w_next = ST_M_DATA;
            ST_M_DATA: if (w_accept)   w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_txValid  = 1'b0;
        w_txSop    = 1'b0;
        w_txEop    = 1'b0;
        w_txData   = 64'd0;
        w_f2cReady = 1'b0;
        unique case (r_state)
            ST_D_HDR, ST_M_HDR: begin
                w_txValid = 1'b1;
                w_txSop   = 1'b1;
                w_txData  = r_hdr;
            end
            ST_D_DATA: begin
                w_txValid  = bus.f2cValid_in;
                w_txData   = bus.f2cData_in;
                w_f2cReady = bus.txReady_in;
                w_txEop    = (r_beatCnt == 4'd15);
            end
            ST_M_DATA: begin
                w_txValid = 1'b1;
                w_txEop   = 1'b1;
                w_txData  = {60'd0, r_wrPtr};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_f2cBase    <= 32'd0;
            r_mtrBase    <= 32'd0;
            r_enable     <= 1'b0;
            r_clrPending <= 1'b0;
            r_wrPtr      <= 4'd0;
            r_rdPtr      <= 4'd0;
            r_beatCnt    <= 4'd0;
            r_hdr        <= 64'd0;
        end else begin
            if (w_wrF2cBase) r_f2cBase <= bus.regWrData_in;
            if (w_wrMtrBase) r_mtrBase <= bus.regWrData_in;
            if (w_wrEnable)  r_enable  <= bus.regWrData_in[0];

            // A fresh disable outranks retiring the previous clear request.
            if (w_wrEnable && !bus.regWrData_in[0]) begin
                r_clrPending <= 1'b1;
            end else if (w_idleClr) begin
                r_clrPending <= 1'b0;
            end

            if (w_idleClr) begin
                r_rdPtr <= 4'd0;
            end else if (w_wrRdPtr) begin
                r_rdPtr <= bus.regWrData_in[3:0];
            end

            if (w_idleClr) begin
                r_wrPtr <= 4'd0;
            end else if (w_lastBeat) begin
                r_wrPtr <= r_wrPtr + 4'd1;
            end

            if ((r_state == ST_D_HDR) && w_accept) begin
                r_beatCnt <= 4'd0;
            end else if ((r_state == ST_D_DATA) && w_accept) begin
                r_beatCnt <= r_beatCnt + 4'd1;
            end

            // Metrics header captures the base now; wrPtr is sent later from r_wrPtr.
            if (w_startReq) begin
                r_hdr <= {22'd0, 10'd32, w_dataAddr};
            end else if (w_lastBeat) begin
                r_hdr <= {22'd0, 10'd2, w_mtrAddr};
            end
        end
    end

    assign bus.txValid_out  = w_txValid;
    assign bus.txSop_out    = w_txSop;
    assign bus.txEop_out    = w_txEop;
    assign bus.txData_out   = w_txData;
    assign bus.f2cReady_out = w_f2cReady;
    assign bus.wrPtr_out    = r_wrPtr;
    assign bus.rdPtr_out    = r_rdPtr;

endmodule

// File: tb/tb_f2c_dma_writer.sv
// Directed bench for f2c_dma_writer: request table plus hand sequences for
// start latency, disable mid-request, reset mid-request and address wrap.
module tb_f2c_dma_writer;
    import tlp_xcvr_pkg::*;

    logic clk_in = 1'b0;
    logic rstn;
    always #5 clk_in = ~clk_in;

    f2c_dma_writer_if bus();

    f2c_dma_writer u_dut (
        .clk_in (clk_in),
        .rstn   (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic        sop;
        logic        eop;
        logic [63:0] d;
    } beat_t;

    // One record per request: stimulus controls and the expected request.
    typedef struct {
        logic        stall;
        logic        chk_idle;
        logic        rd_vld;
        logic [3:0]  rd_val;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wr;
    } vec_t;

    beat_t       beats[$];
    vec_t        vec[39];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          src_idx = 0;
    int          exp_src = 0;
    logic        src_rand  = 1'b0;
    logic        rdy_rand  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_hdr  = 64'd0;
    logic        last_vld  = 1'b0;
    logic        last_sop  = 1'b0;
    logic [63:0] last_dat  = 64'd0;

    function automatic logic [63:0] seq64(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'(i) ^ 32'hA5A5_5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample mid-cycle, advance to just after the edge.
    task automatic tick();
        bus.f2cValid_in = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.f2cData_in  = seq64(src_idx);
        bus.txReady_in  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        if (prev_stall) begin
            chk("hdr_hold_vld", 64'(bus.txValid_out), 64'd1);
            chk("hdr_hold_dat", bus.txData_out, prev_hdr);
        end
        prev_stall = bus.txValid_out && bus.txSop_out && !bus.txReady_in;
        prev_hdr   = bus.txData_out;
        last_vld   = bus.txValid_out;
        last_sop   = bus.txSop_out;
        last_dat   = bus.txData_out;
        if (bus.txValid_out && bus.txReady_in)
            beats.push_back('{sop: bus.txSop_out, eop: bus.txEop_out, d: bus.txData_out});
        if (bus.f2cValid_in && bus.f2cReady_out)
            src_idx++;
        @(posedge clk_in);
        #1;
        bus.regWrValid_in = 1'b0;
    endtask

    task automatic reg_write(input ExtChan ch, input logic [31:0] d);
        bus.regWrValid_in = 1'b1;
        bus.regWrChan_in  = ch;
        bus.regWrData_in  = d;
        tick();
    endtask

    task automatic collect_req(input logic [31:0] addr, input logic [31:0] maddr,
                               input logic [3:0] metric);
        int    t;
        beat_t b;
        t = 0;
        while (beats.size() < 19 && t < 400) begin
            tick();
            t++;
        end
        if (beats.size() < 19) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: got %0d beats expected 19", beats.size());
            beats.delete();
            return;
        end
        b = beats.pop_front();
        chk("d_hdr_sop", 64'(b.sop), 64'd1);
        chk("d_hdr", b.d, {22'd0, 10'd32, addr});
        for (int i = 0; i < 16; i++) begin
            b = beats.pop_front();
            chk("d_dat", b.d, seq64(exp_src));
            exp_src++;
            chk("d_sop", 64'(b.sop), 64'd0);
            chk("d_eop", 64'(b.eop), (i == 15) ? 64'd1 : 64'd0);
        end
        b = beats.pop_front();
        chk("m_hdr_sop", 64'(b.sop), 64'd1);
        chk("m_hdr", b.d, {22'd0, 10'd2, maddr});
        b = beats.pop_front();
        chk("m_dat_eop", 64'(b.eop), 64'd1);
        chk("m_dat", b.d, {60'd0, metric});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vld"}, 64'(bus.txValid_out), 64'd0);
        chk({tag, "_sop"}, 64'(bus.txSop_out), 64'd0);
        chk({tag, "_eop"}, 64'(bus.txEop_out), 64'd0);
        chk({tag, "_dat"}, bus.txData_out, 64'd0);
        chk({tag, "_f2crdy"}, 64'(bus.f2cReady_out), 64'd0);
        chk({tag, "_wrptr"}, 64'(bus.wrPtr_out), 64'd0);
        chk({tag, "_rdptr"}, 64'(bus.rdPtr_out), 64'd0);
    endtask

    initial begin
        int t;

        // Slots 0..14 fill the ring with rdPtr at 0; the 15th stops on full.
        for (int i = 0; i < 15; i++)
            vec[i] = '{stall: 1'b0, chk_idle: (i == 14), rd_vld: (i == 14), rd_val: 4'd1,
                       exp_addr: 32'(i) * 32'h80, exp_wr: 4'(i + 1)};
        vec[15] = '{stall: 1'b0, chk_idle: 1'b1, rd_vld: 1'b1, rd_val: 4'd0,
                    exp_addr: 32'h780, exp_wr: 4'd0};
        // Host keeps rdPtr caught up; slots wrap 15 -> 0.
        for (int k = 0; k < 20; k++)
            vec[16 + k] = '{stall: 1'b0, chk_idle: 1'b0, rd_vld: 1'b1, rd_val: 4'((k % 16) + 1),
                            exp_addr: 32'(k % 16) * 32'h80, exp_wr: 4'((k % 16) + 1)};
        for (int k = 0; k < 3; k++)
            vec[36 + k] = '{stall: 1'b1, chk_idle: 1'b0, rd_vld: 1'b1, rd_val: 4'(k + 5),
                            exp_addr: 32'(k + 4) * 32'h80, exp_wr: 4'(k + 5)};

        rstn              = 1'b0;
        bus.regWrValid_in = 1'b0;
        bus.regWrChan_in  = '0;
        bus.regWrData_in  = 32'd0;
        bus.f2cValid_in   = 1'b1;
        bus.f2cData_in    = seq64(0);
        bus.txReady_in    = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk_outputs_zero("reset");
        rstn = 1'b1;

        // Single request with start-latency check.
        reg_write(F2C_BASE, 32'h0);
        reg_write(MTR_BASE, 32'h100);
        reg_write(DMA_ENABLE, 32'h1);
        tick();
        chk("start_n1_vld", 64'(last_vld), 64'd0);
        tick();
        chk("start_n2_vld", 64'(last_vld), 64'd1);
        chk("start_n2_sop", 64'(last_sop), 64'd1);
        chk("start_n2_hdr", last_dat, {22'd0, 10'd32, 32'h0});

        for (int i = 0; i < 39; i++) begin
            src_rand = vec[i].stall;
            rdy_rand = vec[i].stall;
            collect_req(vec[i].exp_addr, 32'h800, vec[i].exp_wr);
            chk("wr_ptr", 64'(bus.wrPtr_out), 64'(vec[i].exp_wr));
            if (vec[i].chk_idle) begin
                repeat (40) tick();
                chk("idle_beats", 64'(beats.size()), 64'd0);
                chk("idle_vld", 64'(last_vld), 64'd0);
            end
            if (vec[i].rd_vld)
                reg_write(F2C_RDPTR, {28'd0, vec[i].rd_val});
        end
        src_rand = 1'b0;
        rdy_rand = 1'b0;

        // Disable while data beats of slot 7 are in flight.
        t = 0;
        while (beats.size() < 7 && t < 200) begin
            tick();
            t++;
        end
        reg_write(DMA_ENABLE, 32'h0);
        collect_req(32'h380, 32'h800, 4'd8);
        repeat (40) tick();
        chk("dis_beats", 64'(beats.size()), 64'd0);
        chk("dis_wrptr", 64'(bus.wrPtr_out), 64'd0);
        chk("dis_rdptr", 64'(bus.rdPtr_out), 64'd0);

        // Re-enable, then reset during data beat 8.
        reg_write(F2C_RDPTR, 32'h9);
        reg_write(DMA_ENABLE, 32'h1);
        t = 0;
        while (beats.size() < 10 && t < 200) begin
            tick();
            t++;
        end
        chk("reen_beats", 64'(beats.size()), 64'd10);
        if (beats.size() > 0)
            chk("reen_hdr", beats[0].d, {22'd0, 10'd32, 32'h0});
        bus.f2cValid_in = 1'b1;
        bus.f2cData_in  = seq64(src_idx);
        bus.txReady_in  = 1'b1;
        #1;
        chk("pre_rst_vld", 64'(bus.txValid_out), 64'd1);
        chk("pre_rst_rdptr", 64'(bus.rdPtr_out), 64'd9);
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(posedge clk_in);
        #1;
        rstn = 1'b1;
        beats.delete();
        exp_src    = src_idx;
        prev_stall = 1'b0;

        // Unmapped channel must not enable the engine.
        reg_write(ExtChan'(4'd9), 32'h1);
        repeat (20) tick();
        chk("unmapped_beats", 64'(beats.size()), 64'd0);

        // Upper base bits ignored; byte addresses wrap mod 2^32.
        reg_write(F2C_BASE, 32'hFFFF_FFFF);
        reg_write(MTR_BASE, 32'hE000_0010);
        reg_write(DMA_ENABLE, 32'h1);
        collect_req(32'hFFFF_FFF8, 32'h80, 4'd1);
        collect_req(32'h0000_0078, 32'h80, 4'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/f2c_dma_writer.md
# f2c_dma_writer

FPGA→CPU DMA write engine. Pulls 64-bit words from an application stream, packs them into 128-byte (16-QW) memory-write requests targeting a 16-slot circular buffer in host memory, and after each one posts a metrics write carrying the updated write pointer. Sits between the application data source and the TLP transmitter in the PCIe DMA app; host software controls it through the `F2C_BASE`, `MTR_BASE`, `DMA_ENABLE` and `F2C_RDPTR` register channels, with channel constants taken from `tlp_xcvr_pkg`.

## Interface
- No parameters. Channel indices come from `tlp_xcvr_pkg`.
- `clk_in` in 1: PCIe application clock; the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `regWrValid_in` in 1: register-write strobe, one cycle.
- `regWrChan_in` in `ExtChan`: register channel index.
- `regWrData_in` in 32: register-write data.
- `f2cData_in` in 64: source QW.
- `f2cValid_in` in 1: source data valid.
- `f2cReady_out` out 1: source QW consumed this cycle when `f2cValid_in` and `f2cReady_out` are both high.
- `txData_out` out 64: request beat, either a header beat or a data beat.
- `txValid_out` out 1: beat valid.
- `txSop_out` out 1: marks a header beat.
- `txEop_out` out 1: marks the last data beat of a request.
- `txReady_in` in 1: transmitter accepts the beat when `txValid_out` and `txReady_in` are both high.
- `wrPtr_out` out 4: current write slot.
- `rdPtr_out` out 4: last host read pointer.

## Operation
- **Registers**
  - `F2C_BASE`: QW address of the data buffer (32 bit).
  - `MTR_BASE`: QW address of the metrics QW.
  - `F2C_RDPTR`: `rdPtr <= data[3:0]`.
  - `DMA_ENABLE`: `enable <= data[0]`. A write of 0 also sets `clrPending`.
  - Writes to any other channel are ignored.
- **Byte addresses** (32-bit, wrap mod 2^32)
  - Data request: `{F2C_BASE[28:0],3'b0} + {wrPtr,7'b0}`.
  - Metrics request: `{MTR_BASE[28:0],3'b0}`.
- **Header beat layout**
  - `[31:0]` = byte address.
  - `[41:32]` = length in DWs: 32 for data, 2 for metrics.
  - `[63:42]` = 0.
- **Full rule:** full when `(wrPtr+1)&4'hF == rdPtr`. 15 slots are usable. wrPtr == rdPtr means empty, which is the host's wait condition.
- **FSM states:** IDLE, D_HDR, D_DATA, M_HDR, M_DATA.
  - **IDLE**
    - If `clrPending`: clear wrPtr, rdPtr and `clrPending`, and stay in IDLE.
    - Else if `enable && !full`: go to D_HDR.
  - **D_HDR**
    - Drive `txValid_out=1`, `txSop_out=1` and the data header.
    - On accept, clear the beat counter and go to D_DATA.
  - **D_DATA**
    - Pass-through: `txValid_out=f2cValid_in`, `f2cReady_out=txReady_in`, `txData_out=f2cData_in`.
    - `txEop_out=1` when the beat counter is 15.
    - Each accepted beat increments the counter.
    - After beat 15: `wrPtr <= wrPtr+1` (mod 16), then go to M_HDR.
  - **M_HDR**
    - Drive the metrics header.
    - On accept, go to M_DATA.
  - **M_DATA**
    - `txData_out = {60'b0, wrPtr}` (already incremented), `txEop_out=1`.
    - On accept, go to IDLE.
- **Disable mid-request:** clearing `enable` does not abort. The in-flight data request and its metrics write complete. The pointer clear happens on return to IDLE.
- **Simultaneous events**
  - An `F2C_RDPTR` write in the same cycle as the IDLE clear: the clear wins.
  - An `F2C_RDPTR` write in the same cycle as the full check: the check uses the old rdPtr. The new value is visible the next cycle.
- **Idle outputs:** outside D_DATA, `f2cReady_out=0`. In IDLE, `txValid_out=0`.

## Timing
- **Reset values:** all outputs 0, state IDLE, all registers 0 including `enable` and `clrPending`.
- **Registers:** a write in cycle N is visible to the FSM in cycle N+1.
- **Request start latency:** from an enabling `DMA_ENABLE` write in cycle N, with the buffer not full, `txValid_out` rises for the D_HDR beat in cycle N+2.
- **Stall-free request length:** one data request plus its metrics write takes 1+16+1+1 = 19 accepted beats. With no stalls it occupies 19 cycles, and the next D_HDR starts after one IDLE cycle.
- **Header and metrics beats:** outputs are registered and held stable while `txValid_out && !txReady_in`.
- **D_DATA path:** `txValid_out`, `txData_out` and `f2cReady_out` are combinational pass-throughs; the `tx*` outputs are not registered in this state.
- **Pointer update:** wrPtr is updated on the clock edge that accepts data beat 15, so `wrPtr_out` changes on that edge.
- **Asynchronous reset mid-request:** abandons the request immediately. Framing recovery is the transmitter's responsibility.

## Test plan
- **Single request.** Set `F2C_BASE=0`, `MTR_BASE=0x100`, enable; the source supplies SEQ64[0..15].
  - Expect a header with addr 0x0 and len 32, then 16 data beats equal to SEQ64[0..15] with EOP on beat 15.
  - Then a metrics header with addr 0x800 and len 2, then a data beat of 1.
- **Full stop.** rdPtr stays at 0 with the source always valid.
  - Exactly 15 requests are issued, to addrs 0x0, 0x80, …, 0x700. The metrics values run 1..15, then the block idles.
  - Writing `F2C_RDPTR=1` resumes one request, to slot 15 at addr 0x780, with metrics value 0.
- **Wrap.** Run 20 requests while the host advances rdPtr after each one.
  - Slot 15 goes to addr 0x780, followed by slot 0 at addr 0x0. The metrics sequence wraps 15→0.
- **Backpressure.** Toggle `txReady_in` and `f2cValid_in` randomly.
  - Header beats stay stable while stalled.
  - No source QW is lost or duplicated; the data matches SEQ64 in order.
- **Disable mid-request.** Write `DMA_ENABLE=0` at data beat 5.
  - The request completes through its metrics write (value 1). Then wrPtr and rdPtr read 0 and no new request starts.
  - Re-enabling restarts at addr 0x0.
- **Reset mid-request.** Assert `rstn` low during data beat 8.
  - All outputs go to 0 immediately and the FSM is in IDLE.
